// File: rtl/password_checker_if.sv
// Flag/flagResolve and lock/locker handshakes between the password checker
// (master, initiator) and the display handler (slave).
interface password_checker_if;
  logic flag;
  logic flagSelect;
  logic flagResolve;
  logic lock;
  logic locker;

  modport master (
    output flag, flagSelect, lock,
    input  flagResolve, locker
  );

  modport slave (
    input  flag, flagSelect, lock,
    output flagResolve, locker
  );
endinterface

// File: rtl/password_checker.sv
// Keypad code checker: collects digits, compares attempts against a stored code,
// and drives the flag and lock handshakes served by the display handler.
module password_checker #(
  parameter int CODE_LEN  = 4,
  parameter int DIGIT_W   = 4,
  parameter int MAX_FAILS = 3,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DIGIT_W-1:0]               digit_in,
  input  logic                             digit_valid,
  input  logic                             enter,
  input  logic                             clear,
  input  logic                             lock_req,
  password_checker_if.master               hs,
  output logic                             unlocked,
  output logic                             code_set,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count
);

  localparam int CW    = CODE_LEN * DIGIT_W;
  localparam int CNT_W = $clog2(CODE_LEN + 1);
  localparam int FC_W  = $clog2(MAX_FAILS + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CODE_LEN);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_FAILS - 1);
  localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_FAILS);

  typedef enum logic [2:0] {
    LOCKED, FLAG_REQ, FLAG_REL, UNLOCKED, LOCK_REQ
  } state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      entry, code;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic               flag_sel;
  logic               full, match;

  assign full  = (count == CNT_FULL) && !overflow;
  assign match = full && (entry == code);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOCKED;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOCKED:   if (!clear && enter) state_nxt = match ? UNLOCKED : FLAG_REQ;
      FLAG_REQ: if (hs.flagResolve)  state_nxt = FLAG_REL;
      FLAG_REL: if (!hs.flagResolve) state_nxt = LOCKED;
      UNLOCKED: if (lock_req)        state_nxt = LOCK_REQ;
      LOCK_REQ: if (hs.locker)       state_nxt = LOCKED;
      default:                       state_nxt = LOCKED;
    endcase
  end

  always_comb begin
    hs.flag    = 1'b0;
    hs.lock    = 1'b1;
    unlocked   = 1'b0;
    case (state)
      FLAG_REQ: hs.flag  = 1'b1;
      UNLOCKED: unlocked = 1'b1;
      LOCK_REQ: hs.lock  = 1'b0;
      default:  ;
    endcase
  end

  assign hs.flagSelect = flag_sel;

  // Keypad strobes only reach the buffer in LOCKED and UNLOCKED; a lock
  // request wins over a same-cycle keypad strobe and discards the entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry      <= '0;
      count      <= '0;
      overflow   <= 1'b0;
      code       <= DEFAULT_CODE;
      fail_count <= '0;
      flag_sel   <= 1'b0;
      code_set   <= 1'b0;
    end else begin
      code_set <= 1'b0;
      case (state)
        LOCKED, UNLOCKED: begin
          if ((state == UNLOCKED && lock_req) || clear || enter) begin
            entry    <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end else if (digit_valid) begin
            if (count == CNT_FULL) begin
              overflow <= 1'b1;
            end else begin
              entry <= {entry[CW-DIGIT_W-1:0], digit_in};
              count <= count + CNT_W'(1);
            end
          end
          if (state == LOCKED && !clear && enter) begin
            if (match) begin
              fail_count <= '0;
            end else if (fail_count == FC_LAST) begin
              fail_count <= FC_MAX;
              flag_sel   <= 1'b1;
            end else begin
              fail_count <= fail_count + FC_W'(1);
              flag_sel   <= 1'b0;
            end
          end
          if (state == UNLOCKED && !lock_req && !clear && enter && full) begin
            code     <= entry;
            code_set <= 1'b1;
          end
        end
        FLAG_REL: begin
          if (!hs.flagResolve && flag_sel) begin
            fail_count <= '0;
            flag_sel   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_password_checker.sv
// Directed bench for password_checker: one task per scenario, each with
// hand-computed expectations checked inline.
module tb_password_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] digit_in;
  logic       digit_valid, enter, clear, lock_req;
  logic       unlocked, code_set;
  logic [1:0] fail_count;
  int         checks = 0;
  int         fails  = 0;

  password_checker_if hs ();

  password_checker dut (
    .clk(clk), .rst_n(rst_n), .digit_in(digit_in), .digit_valid(digit_valid),
    .enter(enter), .clear(clear), .lock_req(lock_req), .hs(hs),
    .unlocked(unlocked), .code_set(code_set), .fail_count(fail_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic press(input logic [3:0] d);
    digit_in = d; digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic press_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic enter_code(input logic [15:0] c);
    for (int i = 3; i >= 0; i--) press(c[i*4 +: 4]);
    press_enter();
  endtask

  task automatic ack_flag();
    hs.flagResolve = 1'b1;
    tick();
    hs.flagResolve = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (hs.flag !== 1'b0) begin fails++; $display("[TB] FAIL rst_flag: got %b expected 0", hs.flag); end
    checks++; if (hs.flagSelect !== 1'b0) begin fails++; $display("[TB] FAIL rst_flagSelect: got %b expected 0", hs.flagSelect); end
    checks++; if (hs.lock !== 1'b1) begin fails++; $display("[TB] FAIL rst_lock: got %b expected 1", hs.lock); end
    checks++; if (unlocked !== 1'b0) begin fails++; $display("[TB] FAIL rst_unlocked: got %b expected 0", unlocked); end
    checks++; if (code_set !== 1'b0) begin fails++; $display("[TB] FAIL rst_code_set: got %b expected 0", code_set); end
    checks++; if (fail_count !== 2'd0) begin fails++; $display("[TB] FAIL rst_fail_count: got %0d expected 0", fail_count); end
  endtask

  task automatic test_unlock();
    do_reset();
    enter_code(16'h1234);
    checks++; if (unlocked !== 1'b1) begin fails++; $display("[TB] FAIL t1_unlocked: got %b expected 1", unlocked); end
    checks++; if (hs.flag !== 1'b0) begin fails++; $display("[TB] FAIL t1_flag: got %b expected 0", hs.flag); end
    checks++; if (fail_count !== 2'd0) begin fails++; $display("[TB] FAIL t1_fail_count: got %0d expected 0", fail_count); end
  endtask

  task automatic test_wrong_code();
    do_reset();
    enter_code(16'h1235);
    checks++; if (hs.flag !== 1'b1) begin fails++; $display("[TB] FAIL t2_flag: got %b expected 1", hs.flag); end
    checks++; if (hs.flagSelect !== 1'b0) begin fails++; $display("[TB] FAIL t2_flagSelect: got %b expected 0", hs.flagSelect); end
    checks++; if (fail_count !== 2'd1) begin fails++; $display("[TB] FAIL t2_fail_count: got %0d expected 1", fail_count); end
    // keypad is ignored while the flag is pending
    press(4'h1);
    hs.flagResolve = 1'b1;
    tick();
    checks++; if (hs.flag !== 1'b0) begin fails++; $display("[TB] FAIL t2_flag_released: got %b expected 0", hs.flag); end
    hs.flagResolve = 1'b0;
    tick();
    checks++; if (fail_count !== 2'd1) begin fails++; $display("[TB] FAIL t2_fail_kept: got %0d expected 1", fail_count); end
    enter_code(16'h1234);
    checks++; if (unlocked !== 1'b1) begin fails++; $display("[TB] FAIL t2_back_locked_unlock: got %b expected 1", unlocked); end
  endtask

  task automatic test_lockout();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      enter_code(16'h0000);
      checks++; if (hs.flag !== 1'b1) begin fails++; $display("[TB] FAIL t3_flag_%0d: got %b expected 1", i, hs.flag); end
      checks++; if (hs.flagSelect !== (i == 3)) begin fails++; $display("[TB] FAIL t3_flagSelect_%0d: got %b expected %b", i, hs.flagSelect, (i == 3)); end
      checks++; if (fail_count !== 2'(i)) begin fails++; $display("[TB] FAIL t3_fail_count_%0d: got %0d expected %0d", i, fail_count, i); end
      if (i < 3) ack_flag();
    end
    hs.flagResolve = 1'b1;
    tick();
    tick();
    checks++; if (hs.flagSelect !== 1'b1) begin fails++; $display("[TB] FAIL t3_select_held: got %b expected 1", hs.flagSelect); end
    checks++; if (fail_count !== 2'd3) begin fails++; $display("[TB] FAIL t3_count_held: got %0d expected 3", fail_count); end
    hs.flagResolve = 1'b0;
    tick();
    checks++; if (fail_count !== 2'd0) begin fails++; $display("[TB] FAIL t3_count_cleared: got %0d expected 0", fail_count); end
    checks++; if (hs.flagSelect !== 1'b0) begin fails++; $display("[TB] FAIL t3_select_cleared: got %b expected 0", hs.flagSelect); end
  endtask

  task automatic test_new_code();
    do_reset();
    enter_code(16'h1234);
    press(4'h9); press(4'h8); press(4'h7); press_enter();
    checks++; if (code_set !== 1'b0) begin fails++; $display("[TB] FAIL t4_short_no_set: got %b expected 0", code_set); end
    enter_code(16'h9876);
    checks++; if (code_set !== 1'b1) begin fails++; $display("[TB] FAIL t4_code_set: got %b expected 1", code_set); end
    tick();
    checks++; if (code_set !== 1'b0) begin fails++; $display("[TB] FAIL t4_code_set_pulse: got %b expected 0", code_set); end
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    checks++; if (hs.lock !== 1'b0) begin fails++; $display("[TB] FAIL t4_lock_low: got %b expected 0", hs.lock); end
    checks++; if (unlocked !== 1'b0) begin fails++; $display("[TB] FAIL t4_unlocked_low: got %b expected 0", unlocked); end
    tick(); tick();
    checks++; if (hs.lock !== 1'b0) begin fails++; $display("[TB] FAIL t4_lock_hold: got %b expected 0", hs.lock); end
    hs.locker = 1'b1;
    tick();
    hs.locker = 1'b0;
    checks++; if (hs.lock !== 1'b1) begin fails++; $display("[TB] FAIL t4_lock_release: got %b expected 1", hs.lock); end
    enter_code(16'h1234);
    checks++; if (hs.flag !== 1'b1) begin fails++; $display("[TB] FAIL t4_old_code_flag: got %b expected 1", hs.flag); end
    ack_flag();
    enter_code(16'h9876);
    checks++; if (unlocked !== 1'b1) begin fails++; $display("[TB] FAIL t4_new_code_unlock: got %b expected 1", unlocked); end
    checks++; if (fail_count !== 2'd0) begin fails++; $display("[TB] FAIL t4_fail_count: got %0d expected 0", fail_count); end
  endtask

  task automatic test_overflow_priority();
    do_reset();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h4);
    press_enter();
    checks++; if (hs.flag !== 1'b1) begin fails++; $display("[TB] FAIL t5_overflow_flag: got %b expected 1", hs.flag); end
    checks++; if (fail_count !== 2'd1) begin fails++; $display("[TB] FAIL t5_overflow_count: got %0d expected 1", fail_count); end
    ack_flag();
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    clear = 1'b1; enter = 1'b1;
    tick();
    clear = 1'b0; enter = 1'b0;
    checks++; if (unlocked !== 1'b0) begin fails++; $display("[TB] FAIL t5_clear_unlocked: got %b expected 0", unlocked); end
    checks++; if (hs.flag !== 1'b0) begin fails++; $display("[TB] FAIL t5_clear_flag: got %b expected 0", hs.flag); end
    checks++; if (fail_count !== 2'd1) begin fails++; $display("[TB] FAIL t5_clear_count: got %0d expected 1", fail_count); end
    // empty buffer after clear: enter alone is a failed attempt
    press_enter();
    checks++; if (fail_count !== 2'd2) begin fails++; $display("[TB] FAIL t5_empty_enter: got %0d expected 2", fail_count); end
    ack_flag();
    // enter beats a same-cycle digit, leaving only three digits
    press(4'h1); press(4'h2); press(4'h3);
    digit_in = 4'h4; digit_valid = 1'b1; enter = 1'b1;
    tick();
    digit_valid = 1'b0; enter = 1'b0;
    checks++; if (hs.flagSelect !== 1'b1) begin fails++; $display("[TB] FAIL t5_enter_prio_sel: got %b expected 1", hs.flagSelect); end
    checks++; if (unlocked !== 1'b0) begin fails++; $display("[TB] FAIL t5_enter_prio_unl: got %b expected 0", unlocked); end
    ack_flag();
  endtask

  task automatic test_reset_mid_handshake();
    do_reset();
    enter_code(16'h1111);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (hs.flag !== 1'b0) begin fails++; $display("[TB] FAIL t6_flag: got %b expected 0", hs.flag); end
    checks++; if (fail_count !== 2'd0) begin fails++; $display("[TB] FAIL t6_fail_count: got %0d expected 0", fail_count); end
    enter_code(16'h1234);
    enter_code(16'h9876);
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++; if (hs.lock !== 1'b1) begin fails++; $display("[TB] FAIL t6_lock: got %b expected 1", hs.lock); end
    enter_code(16'h1234);
    checks++; if (unlocked !== 1'b1) begin fails++; $display("[TB] FAIL t6_default_code: got %b expected 1", unlocked); end
  endtask

  initial begin
    rst_n = 1'b1; digit_in = '0; digit_valid = 1'b0; enter = 1'b0;
    clear = 1'b0; lock_req = 1'b0; hs.flagResolve = 1'b0; hs.locker = 1'b0;
    #2;
    test_reset();
    test_unlock();
    test_wrong_code();
    test_lockout();
    test_new_code();
    test_overflow_priority();
    test_reset_mid_handshake();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
